// File: rtl/trace_pkg.sv
// trace_pkg
// Shared definitions for the write-back trace buffer: FSM state encodings,
// the layout of one stored entry and helpers for sizing it.
// Entry layout, MSB to LSB: {stamp, load, dest[4:0], data[31:0]}.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FROZEN  = 2'd2
  } trace_state_e;

  // The stamp-independent part of an entry; the stamp is prepended on top.
  typedef struct packed {
    logic        load;
    logic [4:0]  dest;
    logic [31:0] data;
  } wb_rec_t;

  localparam int REC_W     = $bits(wb_rec_t);
  localparam int DATA_LSB  = 0;
  localparam int DEST_LSB  = 32;
  localparam int LOAD_BIT  = 37;
  localparam int STAMP_LSB = REC_W;

  function automatic int entry_width(input int stamp_w);
    return stamp_w + REC_W;
  endfunction

endpackage

// File: rtl/wb_trace_buffer_if.sv
// wb_trace_buffer_if
// Reader-side valid/ready port of the trace buffer. The buffer drives the
// head entry (slave modport); the host reader drives rd_ready (master modport).
//   rd_valid  head entry present
//   rd_ready  reader accepts the head entry
//   rd_stamp  cycle stamp of the head entry
//   rd_load   load flag of the head entry
//   rd_dest   destination register of the head entry
//   rd_data   write-back value of the head entry
interface wb_trace_buffer_if #(parameter int STAMP_W = 16);
  logic               rd_valid;
  logic               rd_ready;
  logic [STAMP_W-1:0] rd_stamp;
  logic               rd_load;
  logic [4:0]         rd_dest;
  logic [31:0]        rd_data;

  modport slave  (output rd_valid, rd_stamp, rd_load, rd_dest, rd_data,
                  input  rd_ready);
  modport master (input  rd_valid, rd_stamp, rd_load, rd_dest, rd_data,
                  output rd_ready);
endinterface

// File: rtl/trace_fifo.sv
// trace_fifo
// Synchronous show-ahead FIFO: dout always presents the oldest entry (zero
// when empty). A push into a full FIFO is accepted only if a pop happens in
// the same cycle; a pop on an empty FIFO is ignored.
//   clk, rst      clock, synchronous active-high reset
//   flush         synchronous empty (pointers and count to zero)
//   push, din     write request and entry
//   pop, dout     read request and head entry
//   full, empty   status
//   count         number of stored entries (0..DEPTH)
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 54
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = count_q;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; dout is masked while empty instead.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer
// Captures W-stage register write-back events while armed, stamps them with
// a free-running cycle counter and queues them for a host reader.
//   clk, rst                       clock, synchronous active-high reset
//   wwreg, wm2reg, wdestReg, wbData W-stage write-back event
//   arm, freeze, clear              control pulses (clear > freeze > arm)
//   rd                              reader port (wb_trace_buffer_if.slave)
//   count                           stored entries
//   overflow                        sticky: an event was dropped while full
//   state                           FSM state (IDLE/CAPTURE/FROZEN)
// Build option: TRACE_SKIP_R0_EN drops events whose destination is $0.
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wwreg,
  input  logic                   wm2reg,
  input  logic [4:0]             wdestReg,
  input  logic [31:0]            wbData,
  input  logic                   arm,
  input  logic                   freeze,
  input  logic                   clear,
  wb_trace_buffer_if.slave       rd,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [1:0]             state
);
  localparam int EW = entry_width(STAMP_W);

  trace_state_e       state_q;
  trace_state_e       state_d;
  logic [STAMP_W-1:0] stamp_q;
  logic               keep_event;
  logic               capture;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  wb_rec_t            wr_rec;
  wb_rec_t            rd_rec;
  logic [EW-1:0]      wr_entry;
  logic [EW-1:0]      rd_entry;

`ifdef TRACE_SKIP_R0_EN
  assign keep_event = (wdestReg != 5'd0);
`else
  assign keep_event = 1'b1;
`endif

  // The current state decides capture; a freeze pulse also blocks the event
  // arriving with it.
  assign capture = (state_q == CAPTURE) && wwreg && !freeze && keep_event;
  assign pop     = !fifo_empty && rd.rd_ready;

  assign wr_rec   = '{load: wm2reg, dest: wdestReg, data: wbData};
  assign wr_entry = {stamp_q, wr_rec};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: clear beats freeze, freeze beats arm.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (freeze) begin
      if (state_q == CAPTURE) state_d = FROZEN;
    end else if (arm) begin
      if (state_q != CAPTURE) state_d = CAPTURE;
    end
  end

  // Free-running stamp; clear deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) stamp_q <= '0;
    else     stamp_q <= stamp_q + STAMP_W'(1);
  end

  // Dropped only when full and the reader does not free a slot this cycle.
  always_ff @(posedge clk) begin
    if (rst || clear)                     overflow <= 1'b0;
    else if (capture && fifo_full && !pop) overflow <= 1'b1;
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clear),
    .push  (capture),
    .din   (wr_entry),
    .pop   (pop),
    .dout  (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign rd_rec      = wb_rec_t'(rd_entry[REC_W-1:0]);
  assign rd.rd_valid = !fifo_empty;
  assign rd.rd_stamp = rd_entry[EW-1:STAMP_LSB];
  assign rd.rd_load  = rd_rec.load;
  assign rd.rd_dest  = rd_rec.dest;
  assign rd.rd_data  = rd_rec.data;
  assign state       = state_q;

endmodule
